// File: rtl/misr_signature_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : misr_signature_checker_pkg
// Brief    : Shared types and constants for the MISR signature checker.
// Revision : 1.0
// ============================================================================
package misr_signature_checker_pkg;

    localparam int PIXEL_WIDTH        = 8;
    localparam int DEFAULT_DATA_WIDTH = PIXEL_WIDTH;
    localparam int DEFAULT_SIG_WIDTH  = 3 * PIXEL_WIDTH;

    localparam logic [23:0] POLY_LEGACY = 24'h000000;
    localparam logic [23:0] POLY_CRC24  = 24'h864CFB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/misr_signature_checker_core.sv
`default_nettype none
// ============================================================================
// Module   : misr_core
// Brief    : Signature register with seed load and polynomial feedback.
// Revision : 1.0
// ============================================================================
module misr_core
    import misr_signature_checker_pkg::*;
#(
    parameter int                   DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int                   SIG_WIDTH  = DEFAULT_SIG_WIDTH,
    parameter logic [SIG_WIDTH-1:0] POLY       = '0,
    parameter logic [SIG_WIDTH-1:0] SEED       = '0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  i_load,
    input  logic                  i_shift_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [SIG_WIDTH-1:0]  o_sig,
    output logic [SIG_WIDTH-1:0]  o_sig_next
);

    logic [SIG_WIDTH-1:0] r_sig;
    logic [SIG_WIDTH-1:0] w_shifted;

    // Feedback taps apply only when the bit shifted out is set.
    assign w_shifted  = {r_sig[SIG_WIDTH-2:0], 1'b0} ^ (r_sig[SIG_WIDTH-1] ? POLY : '0);
    assign o_sig_next = w_shifted ^ SIG_WIDTH'(i_data);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_sig <= SEED;
        end else if (i_load) begin
            r_sig <= SEED;
        end else if (i_shift_en) begin
            r_sig <= o_sig_next;
        end
    end

    assign o_sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/misr_signature_checker.sv
`default_nettype none
// ============================================================================
// Module   : misr_signature_checker
// Brief    : Frame-based MISR compression with golden-signature verdict.
// Revision : 1.0
// ============================================================================
module misr_signature_checker
    import misr_signature_checker_pkg::*;
#(
    parameter int                   DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int                   SIG_WIDTH  = DEFAULT_SIG_WIDTH,
    parameter logic [SIG_WIDTH-1:0] POLY       = POLY_LEGACY,
    parameter logic [SIG_WIDTH-1:0] SEED       = '0,
    parameter int                   CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  frame_len_i,
    input  logic                  en_i,
    input  logic                  rdy_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [SIG_WIDTH-1:0]  golden_i,
    output logic [SIG_WIDTH-1:0]  signature_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o
);

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] r_len;
    logic                 r_pass;
    logic                 w_load;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_zero_len;
    logic [SIG_WIDTH-1:0] w_sig_next;

    assign w_load     = clear_i | start_i;
    assign w_accept   = en_i & rdy_i & (r_state == RUN) & ~w_load;
    assign w_last     = (r_count == r_len - 1'b1);
    assign w_zero_len = (frame_len_i == '0);

    misr_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIG_WIDTH  (SIG_WIDTH),
        .POLY       (POLY),
        .SEED       (SEED)
    ) u_core (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .i_load     (w_load),
        .i_shift_en (w_accept),
        .i_data     (data_i),
        .o_sig      (signature_o),
        .o_sig_next (w_sig_next)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clear_i) begin
            w_state_next = IDLE;
        end else if (start_i) begin
            w_state_next = w_zero_len ? DONE : RUN;
        end else if (w_accept && w_last) begin
            w_state_next = DONE;
        end
    end

    always_comb begin
        busy_o = (r_state == RUN);
        done_o = (r_state == DONE);
        pass_o = (r_state == DONE) & r_pass;
    end

    // The verdict is captured alongside the final signature so both appear together.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_count <= '0;
            r_len   <= '0;
            r_pass  <= 1'b0;
        end else if (clear_i) begin
            r_count <= '0;
            r_len   <= '0;
            r_pass  <= 1'b0;
        end else if (start_i) begin
            r_count <= '0;
            r_len   <= frame_len_i;
            r_pass  <= w_zero_len & (SEED == golden_i);
        end else if (w_accept) begin
            r_count <= r_count + 1'b1;
            if (w_last) begin
                r_pass <= (w_sig_next == golden_i);
            end
        end
    end

    assign count_o = r_count;

endmodule
`default_nettype wire

// File: tb/tb_misr_signature_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_misr_signature_checker
// Brief    : Directed self-checking bench; legacy and feedback instances.
// Revision : 1.0
// ============================================================================
module tb_misr_signature_checker;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        clear_i;
    logic        start_i;
    logic [15:0] frame_len_i;
    logic        en_i;
    logic        rdy_i;
    logic [7:0]  data_i;
    logic [23:0] golden_i;

    logic [23:0] sig_l, sig_f;
    logic [15:0] cnt_l, cnt_f;
    logic        busy_l, busy_f, done_l, done_f, pass_l, pass_f;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    misr_signature_checker #(
        .POLY (24'h000000),
        .SEED (24'h000000)
    ) u_legacy (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clear_i     (clear_i),
        .start_i     (start_i),
        .frame_len_i (frame_len_i),
        .en_i        (en_i),
        .rdy_i       (rdy_i),
        .data_i      (data_i),
        .golden_i    (golden_i),
        .signature_o (sig_l),
        .count_o     (cnt_l),
        .busy_o      (busy_l),
        .done_o      (done_l),
        .pass_o      (pass_l)
    );

    misr_signature_checker #(
        .POLY (24'h00001B),
        .SEED (24'h800000)
    ) u_fbk (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clear_i     (clear_i),
        .start_i     (start_i),
        .frame_len_i (frame_len_i),
        .en_i        (en_i),
        .rdy_i       (rdy_i),
        .data_i      (data_i),
        .golden_i    (golden_i),
        .signature_o (sig_f),
        .count_o     (cnt_f),
        .busy_o      (busy_f),
        .done_o      (done_f),
        .pass_o      (pass_f)
    );

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        clear_i = 0; start_i = 0; en_i = 0; rdy_i = 0; data_i = 8'h00;
    endtask

    task automatic do_start(input logic [15:0] len);
        start_i = 1; frame_len_i = len;
        cyc();
        start_i = 0;
    endtask

    task automatic push(input logic en, input logic rdy, input logic [7:0] d);
        en_i = en; rdy_i = rdy; data_i = d;
        cyc();
        en_i = 0; rdy_i = 0;
    endtask

    task automatic test_reset();
        idle_inputs(); frame_len_i = 0; golden_i = 0;
        reset_i = 1;
        cyc(); cyc();
        reset_i = 0;
        cyc();
        total++; if (sig_l !== 24'h0 || sig_f !== 24'h800000) begin bad++; $display("FAIL reset_sig got %h/%h want 000000/800000", sig_l, sig_f); end
        total++; if ({cnt_l, busy_l, done_l, pass_l} !== 19'h0) begin bad++; $display("FAIL reset_flags got cnt=%0d b=%b d=%b p=%b want 0", cnt_l, busy_l, done_l, pass_l); end
    endtask

    task automatic test_legacy();
        golden_i = 24'h000003;
        do_start(16'd3);
        total++; if (busy_l !== 1'b1 || cnt_l !== 16'd0) begin bad++; $display("FAIL legacy_run got busy=%b cnt=%0d want 1/0", busy_l, cnt_l); end
        push(1, 1, 8'h01);
        push(1, 1, 8'h02);
        total++; if (done_l !== 1'b0 || cnt_l !== 16'd2) begin bad++; $display("FAIL legacy_mid got done=%b cnt=%0d want 0/2", done_l, cnt_l); end
        push(1, 1, 8'h03);
        total++; if (sig_l !== 24'h000003) begin bad++; $display("FAIL legacy_sig got %h want 000003", sig_l); end
        total++; if (done_l !== 1'b1 || busy_l !== 1'b0 || cnt_l !== 16'd3) begin bad++; $display("FAIL legacy_done got d=%b b=%b cnt=%0d want 1/0/3", done_l, busy_l, cnt_l); end
        total++; if (pass_l !== 1'b1) begin bad++; $display("FAIL legacy_pass got %b want 1", pass_l); end
        push(1, 1, 8'hAA);
        total++; if (sig_l !== 24'h000003 || cnt_l !== 16'd3 || pass_l !== 1'b1) begin bad++; $display("FAIL done_hold got sig=%h cnt=%0d p=%b want 000003/3/1", sig_l, cnt_l, pass_l); end
    endtask

    task automatic test_feedback();
        golden_i = 24'h00001C;
        do_start(16'd1);
        push(1, 1, 8'h00);
        total++; if (sig_f !== 24'h00001B) begin bad++; $display("FAIL fbk_sig got %h want 00001B", sig_f); end
        total++; if (done_f !== 1'b1 || pass_f !== 1'b0) begin bad++; $display("FAIL fbk_verdict got d=%b p=%b want 1/0", done_f, pass_f); end
    endtask

    task automatic test_handshake_gaps();
        golden_i = 24'h000003;
        do_start(16'd3);
        push(1, 0, 8'hFF);
        total++; if (cnt_l !== 16'd0 || sig_l !== 24'h0) begin bad++; $display("FAIL gap0 got cnt=%0d sig=%h want 0/000000", cnt_l, sig_l); end
        push(1, 1, 8'h01);
        total++; if (cnt_l !== 16'd1) begin bad++; $display("FAIL gap_acc1 got cnt=%0d want 1", cnt_l); end
        push(1, 0, 8'hFF);
        push(0, 1, 8'hFF);
        total++; if (cnt_l !== 16'd1 || sig_l !== 24'h000001) begin bad++; $display("FAIL gap_hold got cnt=%0d sig=%h want 1/000001", cnt_l, sig_l); end
        push(1, 1, 8'h02);
        push(1, 0, 8'hFF);
        push(1, 1, 8'h03);
        total++; if (sig_l !== 24'h000003 || cnt_l !== 16'd3 || done_l !== 1'b1 || pass_l !== 1'b1) begin bad++; $display("FAIL gap_final got sig=%h cnt=%0d d=%b p=%b want 000003/3/1/1", sig_l, cnt_l, done_l, pass_l); end
    endtask

    task automatic test_zero_length();
        golden_i = 24'h000000;
        do_start(16'd0);
        total++; if (done_l !== 1'b1 || busy_l !== 1'b0 || sig_l !== 24'h0 || cnt_l !== 16'd0 || pass_l !== 1'b1) begin bad++; $display("FAIL zero_legacy got d=%b b=%b sig=%h cnt=%0d p=%b want 1/0/000000/0/1", done_l, busy_l, sig_l, cnt_l, pass_l); end
        total++; if (done_f !== 1'b1 || sig_f !== 24'h800000 || pass_f !== 1'b0) begin bad++; $display("FAIL zero_fbk got d=%b sig=%h p=%b want 1/800000/0", done_f, sig_f, pass_f); end
        golden_i = 24'h800000;
        do_start(16'd0);
        total++; if (pass_f !== 1'b1 || pass_l !== 1'b0) begin bad++; $display("FAIL zero_golden got pf=%b pl=%b want 1/0", pass_f, pass_l); end
    endtask

    task automatic test_restart_clear();
        do_start(16'd4);
        push(1, 1, 8'h01);
        push(1, 1, 8'h03);
        total++; if (sig_l !== 24'h000001 || sig_f !== 24'h000037 || cnt_l !== 16'd2) begin bad++; $display("FAIL pre_restart got %h/%h cnt=%0d want 000001/000037/2", sig_l, sig_f, cnt_l); end
        en_i = 1; rdy_i = 1; data_i = 8'h55;
        do_start(16'd4);
        en_i = 0; rdy_i = 0;
        total++; if (sig_l !== 24'h0 || sig_f !== 24'h800000 || cnt_l !== 16'd0 || busy_l !== 1'b1 || done_l !== 1'b0) begin bad++; $display("FAIL restart got %h/%h cnt=%0d b=%b d=%b want 000000/800000/0/1/0", sig_l, sig_f, cnt_l, busy_l, done_l); end
        push(1, 1, 8'h07);
        clear_i = 1; start_i = 1; frame_len_i = 16'd2;
        cyc();
        clear_i = 0; start_i = 0;
        total++; if (sig_l !== 24'h0 || sig_f !== 24'h800000 || {cnt_l, busy_l, done_l, pass_l} !== 19'h0) begin bad++; $display("FAIL clear_start got %h/%h cnt=%0d b=%b d=%b p=%b want reset values", sig_l, sig_f, cnt_l, busy_l, done_l, pass_l); end
        push(1, 1, 8'h09);
        total++; if (sig_l !== 24'h0 || cnt_l !== 16'd0) begin bad++; $display("FAIL idle_ignore got sig=%h cnt=%0d want 000000/0", sig_l, cnt_l); end
    endtask

    task automatic test_async_reset();
        do_start(16'd4);
        push(1, 1, 8'h05);
        #2 reset_i = 1;
        #1;
        total++; if (sig_l !== 24'h0 || sig_f !== 24'h800000 || {cnt_l, busy_l, done_l, pass_l} !== 19'h0) begin bad++; $display("FAIL async_reset got %h/%h cnt=%0d b=%b want reset values", sig_l, sig_f, cnt_l, busy_l); end
        @(negedge clk_i);
        reset_i = 0;
        cyc();
        push(1, 1, 8'hFF);
        push(1, 1, 8'h12);
        total++; if (sig_l !== 24'h0 || cnt_l !== 16'd0 || busy_l !== 1'b0) begin bad++; $display("FAIL post_reset got sig=%h cnt=%0d b=%b want 000000/0/0", sig_l, cnt_l, busy_l); end
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_feedback();
        test_handshake_gaps();
        test_zero_length();
        test_restart_clear();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/misr_signature_checker.md
Name: misr_signature_checker

Overview:
- Parametrised multiple-input signature register (MISR) that compresses a frame of output pixels into a signature and compares it against a golden value.
- Generalises the shift-XOR signature analyzer in three ways: configurable width, feedback polynomial and seed; a frame-length counter; and a start/run/done FSM with a registered pass/fail verdict.
- Sits on the filter output stream for on-chip self-test of the gray/Sobel pipeline.

Parameters:
- DATA_WIDTH, 8: width of the sampled pixel.
- SIG_WIDTH, 24: signature width. Must be greater than or equal to DATA_WIDTH.
- POLY, 24'h000000: feedback taps, XORed into the register when the shifted-out MSB is 1. Value 0 gives the legacy plain shift-XOR behaviour.
- SEED, 24'h000000: signature value loaded on reset, clear_i and start_i.
- CNT_WIDTH, 16: width of the frame-length counter.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- reset_i  in  1  asynchronous reset, active-high.
- clear_i  in  1  synchronous clear to the reset state; highest priority after reset.
- start_i  in  1  begin a new frame capture (pulse).
- frame_len_i  in  CNT_WIDTH  number of samples to compress; sampled on start_i.
- en_i  in  1  data qualifier from the producer.
- rdy_i  in  1  downstream ready; a sample is accepted only when en_i && rdy_i.
- data_i  in  DATA_WIDTH  pixel sample.
- golden_i  in  SIG_WIDTH  expected signature; sampled on the DONE-entry cycle.
- signature_o  out  SIG_WIDTH  current signature register.
- count_o  out  CNT_WIDTH  samples accepted in the current frame.
- busy_o  out  1  high while in RUN.
- done_o  out  1  high while in DONE.
- pass_o  out  1  registered verdict; valid only while done_o=1, otherwise 0.

Behaviour:
- Reset (and clear_i): state IDLE; signature_o=SEED; count_o=0; busy_o=0; done_o=0; pass_o=0.
- MISR update on an accepted sample: sig_next = ({sig[SIG_WIDTH-2:0],1'b0} ^ (sig[SIG_WIDTH-1] ? POLY : 0)) ^ zero_extend(data_i).
  - The signature changes only on accepted samples in RUN.
  - The update is visible on signature_o one cycle after acceptance.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start_i loads sig=SEED, count=0, len_q=frame_len_i, then goes to RUN. If frame_len_i==0, it goes directly to DONE instead, with sig=SEED and pass computed against golden_i in the same cycle.
  - RUN: each accepted sample does the MISR update and count+1. On the accepted sample where count==len_q-1, the next state is DONE.
  - DONE entry: pass_o <= (sig_next == golden_i), registered together with the final signature. done_o rises in the same cycle that signature_o shows the final value (latency 1 after the last sample).
  - DONE: holds signature, count and pass. Samples are ignored. start_i begins a new frame exactly as from IDLE.
- start_i during RUN aborts and restarts: seed reload, count=0, new length latched, stays in RUN.
- clear_i beats start_i when both are asserted in the same cycle.
- Samples with en_i=1 and rdy_i=0 are not accepted and cause no change.
- Samples in IDLE are ignored.
- Counter never wraps: the maximum frame is 2^CNT_WIDTH-1 samples.
- Reset mid-frame: immediate return to the reset state, no verdict.
- golden_i needs to be stable only on the DONE-entry cycle.

Decomposition:
- Shared package:
  - state enum {IDLE, RUN, DONE}.
  - Default DATA_WIDTH/SIG_WIDTH constants, taken from the existing pixel-width constants.
  - Named polynomial constants: POLY_LEGACY=0, POLY_CRC24=24'h864CFB.
- Sub-module misr_core:
  - Contains the signature register, seed load and feedback logic.
  - Parametrised by DATA_WIDTH, SIG_WIDTH, POLY and SEED.
  - Inputs: load, shift_en, data.
- The top level holds the FSM, the counter and the comparison.

Test Plan:
- Legacy mode (POLY=0, SEED=0, len=3), data 8'h01, 8'h02, 8'h03 accepted back to back -> signature_o=24'h000003, done_o rises 1 cycle after the third sample, count_o=3; golden_i=24'h000003 gives pass_o=1.
- Feedback: POLY=24'h00001B, SEED=24'h800000, len=1, data 8'h00 -> signature_o=24'h00001B; golden_i=24'h00001C gives pass_o=0, done_o=1.
- Handshake gaps: len=3, same data as the first scenario with en_i=1 and rdy_i=0 on alternate cycles -> identical signature 24'h000003; count_o increments only on accepted cycles.
- Zero length: start_i with frame_len_i=0 -> DONE next cycle, signature_o=SEED, pass_o=(golden_i==SEED).
- Restart and clear: start_i at sample 2 of a len=4 frame -> seed reloaded, count_o=0, busy_o stays 1. clear_i together with start_i -> IDLE with all outputs at reset values.
- Async reset_i asserted mid-RUN without a clock edge -> outputs at reset values immediately; samples after release are ignored until start_i.
